// File: rtl/video_pixel_fifo.sv
// Pixel ring buffer that loads multi-pixel words and emits one registered
// pixel per request. It provides level, watermark, full/empty and sticky error flags.
module video_pixel_fifo #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 2,
  parameter int DEPTH_WORDS  = 4,
  parameter int WATERMARK    = 2
) (
  input  logic                                             clk25MHz,
  input  logic                                             rst,
  input  logic                                             en,
  input  logic                                             clear,
  input  logic                                             load,
  input  logic [PIX_PER_WORD*PIX_W-1:0]                    data,
  input  logic                                             need_pixel,
  output logic [PIX_W-1:0]                                 video,
  output logic                                             video_valid,
  output logic [$clog2(DEPTH_WORDS*PIX_PER_WORD+1)-1:0]    level,
  output logic                                             empty,
  output logic                                             full,
  output logic                                             watermark_on,
  output logic                                             underrun,
  output logic                                             overflow
);

  localparam int CAP = DEPTH_WORDS * PIX_PER_WORD;
  localparam int LW  = $clog2(CAP + 1);
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int SW  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [LW-1:0] FULL_THR = LW'(CAP - PIX_PER_WORD);
  localparam logic [LW-1:0] WM_THR   = LW'(WATERMARK);
  localparam logic [LW-1:0] WORD_INC = LW'(PIX_PER_WORD);
  localparam logic [SW-1:0] SEL_LAST = SW'(PIX_PER_WORD - 1);

  logic [AW-1:0]    wr_word_reg;
  logic [AW-1:0]    rd_word_reg;
  logic [SW-1:0]    rd_sel_reg;
  logic [LW-1:0]    level_reg;
  logic             do_load;
  logic             do_pop;
  logic             wr_en;
  logic [PIX_W-1:0] bank_rd [PIX_PER_WORD];

  assign level        = level_reg;
  assign empty        = (level_reg == '0);
  assign full         = (level_reg > FULL_THR);
  assign watermark_on = (level_reg <= WM_THR);

  // Both decisions use the registered level, so a same-cycle pop never makes room for a load.
  assign do_load = load && !full;
  assign do_pop  = need_pixel && !empty;
  assign wr_en   = en && !clear && do_load;

  // One bank per pixel slot of a word: a whole word lands in a single write cycle.
  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_bank
    logic [PIX_W-1:0] bank_mem [DEPTH_WORDS];

    always_ff @(posedge clk25MHz) begin
      if (wr_en) begin
        bank_mem[wr_word_reg] <= data[(PIX_PER_WORD-gi)*PIX_W-1 -: PIX_W];
      end
    end

    assign bank_rd[gi] = bank_mem[rd_word_reg];
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      wr_word_reg <= '0;
      rd_word_reg <= '0;
      rd_sel_reg  <= '0;
      level_reg   <= '0;
      video       <= '0;
      video_valid <= 1'b0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else if (en) begin
      if (clear) begin
        wr_word_reg <= '0;
        rd_word_reg <= '0;
        rd_sel_reg  <= '0;
        level_reg   <= '0;
        video       <= '0;
        video_valid <= 1'b0;
        underrun    <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (do_load) begin
          wr_word_reg <= wr_word_reg + AW'(1);
        end
        if (load && full) begin
          overflow <= 1'b1;
        end

        if (do_pop) begin
          video       <= bank_rd[rd_sel_reg];
          video_valid <= 1'b1;
          if (rd_sel_reg == SEL_LAST) begin
            rd_sel_reg  <= '0;
            rd_word_reg <= rd_word_reg + AW'(1);
          end else begin
            rd_sel_reg <= rd_sel_reg + SW'(1);
          end
        end else if (need_pixel) begin
          video       <= '0;
          video_valid <= 1'b0;
          underrun    <= 1'b1;
        end else begin
          video_valid <= 1'b0;
        end

        case ({do_load, do_pop})
          2'b10:   level_reg <= level_reg + WORD_INC;
          2'b01:   level_reg <= level_reg - LW'(1);
          2'b11:   level_reg <= level_reg + WORD_INC - LW'(1);
          default: level_reg <= level_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_pixel_fifo.sv
// Directed bench for video_pixel_fifo with default parameters (8-bit pixels,
// two pixels per word, four words deep, watermark 2).
module tb_video_pixel_fifo;

  logic        clk25MHz = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        need_pixel = 1'b0;
  logic [7:0]  video;
  logic        video_valid;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        watermark_on;
  logic        underrun;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  video_pixel_fifo #(
    .PIX_W(8), .PIX_PER_WORD(2), .DEPTH_WORDS(4), .WATERMARK(2)
  ) dut (
    .clk25MHz(clk25MHz), .rst(rst), .en(en), .clear(clear), .load(load),
    .data(data), .need_pixel(need_pixel), .video(video),
    .video_valid(video_valid), .level(level), .empty(empty), .full(full),
    .watermark_on(watermark_on), .underrun(underrun), .overflow(overflow)
  );

  always #20 clk25MHz = ~clk25MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic ld, input logic [15:0] d, input logic np);
    load       = ld;
    data       = d;
    need_pixel = np;
    @(posedge clk25MHz);
    #1;
    load       = 1'b0;
    need_pixel = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] px, input logic [3:0] lvl);
    cyc(1'b0, 16'h0, 1'b1);
    check({tag, ".video"}, video, px);
    check({tag, ".valid"}, video_valid, 1'b1);
    check({tag, ".level"}, level, lvl);
  endtask

  initial begin
    // Reset then idle
    #5 rst = 1'b1;
    #50 rst = 1'b0;
    @(posedge clk25MHz);
    #1;
    check("rst.video", video, 8'h00);
    check("rst.valid", video_valid, 1'b0);
    check("rst.level", level, 4'd0);
    check("rst.empty", empty, 1'b1);
    check("rst.full", full, 1'b0);
    check("rst.wm", watermark_on, 1'b1);
    check("rst.underrun", underrun, 1'b0);
    check("rst.overflow", overflow, 1'b0);

    cyc(1'b0, 16'h0, 1'b1);
    check("ur.video", video, 8'h00);
    check("ur.valid", video_valid, 1'b0);
    check("ur.underrun", underrun, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    check("ur.sticky", underrun, 1'b1);
    clear = 1'b1;
    cyc(1'b0, 16'h0, 1'b0);
    clear = 1'b0;
    check("clr.underrun", underrun, 1'b0);

    // Single word, two pops
    cyc(1'b1, 16'hA1B2, 1'b0);
    check("w1.level", level, 4'd2);
    pop_expect("w1.p0", 8'hA1, 4'd1);
    pop_expect("w1.p1", 8'hB2, 4'd0);
    check("w1.empty", empty, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    check("w1.hold_video", video, 8'hB2);
    check("w1.idle_valid", video_valid, 1'b0);

    // Fill twice from an offset start so both pointers wrap
    for (int rep = 0; rep < 2; rep++) begin
      cyc(1'b1, 16'h0102, 1'b0);
      cyc(1'b1, 16'h0304, 1'b0);
      cyc(1'b1, 16'h0506, 1'b0);
      cyc(1'b1, 16'h0708, 1'b0);
      check("fill.level", level, 4'd8);
      check("fill.full", full, 1'b1);
      check("fill.wm", watermark_on, 1'b0);
      cyc(1'b1, 16'hFFFF, 1'b0);
      check("fill.drop_level", level, 4'd8);
      check("fill.overflow", overflow, 1'b1);
      for (int i = 0; i < 8; i++) begin
        pop_expect($sformatf("fill%0d.p%0d", rep, i), 8'(i + 1), 4'(7 - i));
      end
      check("fill.empty", empty, 1'b1);
    end

    // Simultaneous load and pop
    clear = 1'b1;
    cyc(1'b0, 16'h0, 1'b0);
    clear = 1'b0;
    check("sim.clr_overflow", overflow, 1'b0);
    cyc(1'b1, 16'h1011, 1'b0);
    cyc(1'b1, 16'h1213, 1'b0);
    pop_expect("sim.pre", 8'h10, 4'd3);
    cyc(1'b1, 16'hC0C1, 1'b1);
    check("sim.video", video, 8'h11);
    check("sim.level", level, 4'd4);
    pop_expect("sim.a", 8'h12, 4'd3);
    pop_expect("sim.b", 8'h13, 4'd2);
    pop_expect("sim.c", 8'hC0, 4'd1);
    cyc(1'b1, 16'h2021, 1'b0);
    cyc(1'b1, 16'h2223, 1'b0);
    cyc(1'b1, 16'h2425, 1'b0);
    check("sim7.level", level, 4'd7);
    check("sim7.full", full, 1'b1);
    cyc(1'b1, 16'hEEEE, 1'b1);
    check("sim7.video", video, 8'hC1);
    check("sim7.level_after", level, 4'd6);
    check("sim7.overflow", overflow, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pop_expect($sformatf("sim7.p%0d", i), 8'h20 + 8'(i), 4'(5 - i));
    end
    cyc(1'b0, 16'h0, 1'b1);
    check("sim7.underrun", underrun, 1'b1);

    // Watermark
    cyc(1'b1, 16'h3031, 1'b0);
    cyc(1'b1, 16'h3233, 1'b0);
    pop_expect("wm.p0", 8'h30, 4'd3);
    check("wm.off_at3", watermark_on, 1'b0);
    pop_expect("wm.p1", 8'h31, 4'd2);
    check("wm.on_at2", watermark_on, 1'b1);
    cyc(1'b1, 16'h3435, 1'b0);
    check("wm.level4", level, 4'd4);
    check("wm.off_at4", watermark_on, 1'b0);

    // Clock enable hold, then clear
    cyc(1'b1, 16'h3637, 1'b0);
    pop_expect("en.pre", 8'h32, 4'd5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h9999, 1'b1);
    end
    check("en.level", level, 4'd5);
    check("en.video", video, 8'h32);
    check("en.valid_hold", video_valid, 1'b1);
    check("en.overflow", overflow, 1'b1);
    en = 1'b1;
    pop_expect("en.post", 8'h33, 4'd4);
    clear = 1'b1;
    cyc(1'b1, 16'h9999, 1'b1);
    clear = 1'b0;
    check("clr.level", level, 4'd0);
    check("clr.empty", empty, 1'b1);
    check("clr.video", video, 8'h00);
    check("clr.valid", video_valid, 1'b0);
    check("clr.underrun2", underrun, 1'b0);
    check("clr.overflow", overflow, 1'b0);
    cyc(1'b1, 16'h4142, 1'b0);
    pop_expect("clr.p0", 8'h41, 4'd1);
    pop_expect("clr.p1", 8'h42, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
